// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM state encoding,
// Wishbone register offsets and register bit positions.
package ps2_pkg;

  // Receive FSM states, one per field of the 11-bit device-to-host frame.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // Word offsets, selected by bus.adr[3:2].
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // STATUS register bit positions.
  localparam int unsigned STAT_NONEMPTY   = 0;
  localparam int unsigned STAT_FULL       = 1;
  localparam int unsigned STAT_PARITY_ERR = 2;
  localparam int unsigned STAT_FRAME_ERR  = 3;
  localparam int unsigned STAT_OVERFLOW   = 4;
  localparam int unsigned STAT_COUNT_LSB  = 8;

  // CTRL register bit positions.
  localparam int unsigned CTRL_IRQ_EN = 0;

  // DATA register: set when the returned byte is a real FIFO entry.
  localparam int unsigned DATA_VALID_BIT = 31;

endpackage

// File: rtl/if_wb.sv
// Classic Wishbone register-port bundle (32-bit address and data).
//   adr   : byte address from the master
//   dat_i : write data, master to slave
//   dat_o : read data, slave to master
//   we    : write enable
//   cyc   : bus cycle in progress
//   stb   : strobe, this slave is addressed
//   ack   : single-cycle acknowledge from the slave
interface if_wb;
  logic [31:0] adr;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;

  modport slave  (input adr, dat_i, we, cyc, stb, output dat_o, ack);
  modport master (output adr, dat_i, we, cyc, stb, input dat_o, ack);
endinterface

// File: rtl/ps2_rx_fifo.sv
// Synchronous byte FIFO for received scan codes.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data this cycle
//   push_data  : byte to write
//   pop        : discard the head entry this cycle
//   head       : current head byte (meaningful when !empty)
//   empty/full : occupancy flags
//   count      : number of stored entries, 0..2^AWIDTH
//   overflow   : one-cycle pulse when a push was dropped because full
// A push and a pop in the same cycle both take effect; on an empty FIFO the
// pop has nothing to remove, so only the push lands.
module ps2_rx_fifo #(
  parameter int unsigned AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [7:0]        push_data,
  input  logic              pop,
  output logic [7:0]        head,
  output logic              empty,
  output logic              full,
  output logic [AWIDTH:0]   count,
  output logic              overflow
);

  localparam logic [AWIDTH:0] DEPTH = {1'b1, {AWIDTH{1'b0}}};

  logic [7:0]        mem [2**AWIDTH];
  logic [AWIDTH-1:0] rd_ptr;
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH:0]   count_q;
  logic              do_push;
  logic              do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH);
  assign count = count_q;
  assign head  = mem[rd_ptr];

  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && !do_push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AWIDTH'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AWIDTH'(1);
      if (do_push && !do_pop)
        count_q <= count_q + (AWIDTH+1)'(1);
      else if (do_pop && !do_push)
        count_q <= count_q - (AWIDTH+1)'(1);
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// Wishbone-slave PS/2 keyboard receiver.
// Receives device-to-host frames (start, 8 data LSB first, odd parity, stop),
// buffers good bytes in a FIFO and reports line errors in STATUS.
//   clk_i     : system clock
//   rst_i     : asynchronous active-high reset
//   bus       : Wishbone slave register port (DATA, STATUS, CTRL)
//   ps2_clk   : PS/2 clock from the device, asynchronous
//   ps2_dat   : PS/2 data from the device, asynchronous
//   interrupt : level interrupt, irq_en & FIFO non-empty, registered
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int unsigned CLKFREQ     = 10_000_000,
  parameter int unsigned TIMEOUT_US  = 2000,
  parameter int unsigned FIFO_AWIDTH = 4,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  if_wb.slave  bus,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic interrupt
);

  localparam int unsigned TO_CYCLES = CLKFREQ / 1_000_000 * TIMEOUT_US;
  localparam int unsigned TO_W      = $clog2(TO_CYCLES + 1);

  // ---------------- input conditioning ----------------
  logic [1:0]            clk_sync;
  logic [1:0]            dat_sync;
  logic [FILTER_LEN-1:0] clk_hist;
  logic                  clk_filt;
  logic                  fe;
  logic                  dat_s;

  assign dat_s = dat_sync[1];

  // Both lines idle high, so the synchronisers and filter reset to 1 and a
  // reset never fabricates a falling edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_hist <= '1;
      clk_filt <= 1'b1;
      fe       <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      clk_hist <= {clk_hist[FILTER_LEN-2:0], clk_sync[1]};
      fe       <= 1'b0;
      if (&clk_hist && !clk_filt) begin
        clk_filt <= 1'b1;
      end else if (!(|clk_hist) && clk_filt) begin
        clk_filt <= 1'b0;
        fe       <= 1'b1;
      end
    end
  end

  // ---------------- frame receiver ----------------
  ps2_state_t      state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_bit;
  logic [TO_W-1:0] to_cnt;
  logic            push_stb;
  logic            perr_stb;
  logic            ferr_stb;
  logic            parity_ok;

  assign parity_ok = ^{shreg, par_bit};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      to_cnt   <= '0;
      push_stb <= 1'b0;
      perr_stb <= 1'b0;
      ferr_stb <= 1'b0;
    end else begin
      push_stb <= 1'b0;
      perr_stb <= 1'b0;
      ferr_stb <= 1'b0;
      if (fe) begin
        to_cnt <= '0;
        unique case (state)
          IDLE: begin
            if (!dat_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg <= {dat_s, shreg[7:1]};
            if (bit_cnt == 3'd7) state <= PARITY;
            else                 bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: begin
            par_bit <= dat_s;
            state   <= STOP;
          end
          STOP: begin
            state    <= IDLE;
            push_stb <= dat_s && parity_ok;
            ferr_stb <= !dat_s;
            perr_stb <= !parity_ok;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (to_cnt == TO_W'(TO_CYCLES)) begin
          state    <= IDLE;
          to_cnt   <= '0;
          ferr_stb <= 1'b1;
        end else begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end
    end
  end

  // ---------------- FIFO ----------------
  logic [7:0]           fifo_head;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [FIFO_AWIDTH:0] fifo_count;
  logic                 fifo_ovf;
  logic                 fifo_pop;

  ps2_rx_fifo #(
    .AWIDTH (FIFO_AWIDTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push_stb),
    .push_data (shreg),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count),
    .overflow  (fifo_ovf)
  );

  // ---------------- Wishbone registers ----------------
  logic        ack_q;
  logic [31:0] dat_q;
  logic [1:0]  acc_adr;
  logic        acc_we;
  logic [4:0]  acc_wdat;
  logic        wb_req;
  logic [31:0] rd_data;
  logic        irq_en;
  logic        parity_err;
  logic        frame_err;
  logic        overflow;
  logic        wr_status;
  logic        wr_ctrl;
  logic        unused_ok;

  assign bus.ack   = ack_q;
  assign bus.dat_o = dat_q;
  assign wb_req    = bus.cyc && bus.stb && !ack_q;

  always_comb begin
    rd_data = '0;
    unique case (bus.adr[3:2])
      REG_DATA: begin
        rd_data[DATA_VALID_BIT] = !fifo_empty;
        rd_data[7:0]            = fifo_empty ? 8'h00 : fifo_head;
      end
      REG_STATUS: begin
        rd_data[STAT_NONEMPTY]   = !fifo_empty;
        rd_data[STAT_FULL]       = fifo_full;
        rd_data[STAT_PARITY_ERR] = parity_err;
        rd_data[STAT_FRAME_ERR]  = frame_err;
        rd_data[STAT_OVERFLOW]   = overflow;
        rd_data[STAT_COUNT_LSB +: FIFO_AWIDTH+1] = fifo_count;
      end
      REG_CTRL: rd_data[CTRL_IRQ_EN] = irq_en;
      default: ;
    endcase
  end

  // The access is captured at request time so its side effects in the ack
  // cycle do not depend on the master holding adr/we/dat_i through ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      acc_adr  <= '0;
      acc_we   <= 1'b0;
      acc_wdat <= '0;
    end else begin
      ack_q <= wb_req;
      dat_q <= wb_req ? rd_data : '0;
      if (wb_req) begin
        acc_adr  <= bus.adr[3:2];
        acc_we   <= bus.we;
        acc_wdat <= bus.dat_i[4:0];
      end
    end
  end

  // The head is unchanged between request and ack (only this path pops), so
  // popping on the returned valid bit removes exactly the byte reported.
  assign fifo_pop  = ack_q && !acc_we && (acc_adr == REG_DATA) && dat_q[DATA_VALID_BIT];
  assign wr_status = ack_q && acc_we && (acc_adr == REG_STATUS);
  assign wr_ctrl   = ack_q && acc_we && (acc_adr == REG_CTRL);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_en     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      interrupt  <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= acc_wdat[CTRL_IRQ_EN];
      parity_err <= perr_stb || (parity_err && !(wr_status && acc_wdat[STAT_PARITY_ERR]));
      frame_err  <= ferr_stb || (frame_err  && !(wr_status && acc_wdat[STAT_FRAME_ERR]));
      overflow   <= fifo_ovf || (overflow   && !(wr_status && acc_wdat[STAT_OVERFLOW]));
      interrupt  <= irq_en && !fifo_empty;
    end
  end

  assign unused_ok = ^{bus.adr[31:4], bus.adr[1:0], bus.dat_i[31:5], acc_wdat[1]};

endmodule

// File: tb/tb_ps2_kbd_rx.sv
module tb_ps2_kbd_rx;

  logic clk;
  logic rst;
  logic ps2_clk;
  logic ps2_dat;
  logic interrupt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  if_wb wb ();

  // Scaled timing: 1 MHz and 200 us give a 200-cycle timeout; a PS/2 bit
  // is 80 cycles, i.e. 12.5 kHz at this clock.
  ps2_kbd_rx #(
    .CLKFREQ     (1_000_000),
    .TIMEOUT_US  (200),
    .FIFO_AWIDTH (4),
    .FILTER_LEN  (4)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (wb),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .interrupt (interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic wb_access(input logic [1:0] idx, input logic we, input logic [31:0] wdat,
                           output logic [31:0] rdat);
    logic got;
    got  = 1'b0;
    rdat = '0;
    @(negedge clk);
    wb.adr   = {28'd0, idx, 2'b00};
    wb.we    = we;
    wb.dat_i = wdat;
    wb.cyc   = 1'b1;
    wb.stb   = 1'b1;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      if (wb.ack) begin
        got  = 1'b1;
        rdat = wb.dat_o;
      end
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    wb.cyc = 1'b0;
    wb.stb = 1'b0;
    wb.we  = 1'b0;
  endtask

  task automatic rd_expect(input string tag, input logic [1:0] idx, input logic [31:0] exp);
    logic [31:0] d;
    wb_access(idx, 1'b0, 32'd0, d);
    chk(tag, d, exp);
  endtask

  task automatic wr(input logic [1:0] idx, input logic [31:0] wdat);
    logic [31:0] d;
    wb_access(idx, 1'b1, wdat, d);
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_dat = b;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (40) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  // Sends the first nbits of the frame start/data/parity/stop.
  task automatic ps2_frame(input logic [7:0] d, input logic par_flip, input logic stop_v,
                           input int unsigned nbits);
    logic [10:0] f;
    f = {stop_v, (~^d) ^ par_flip, d, 1'b0};
    for (int unsigned i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2_dat = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_dat  = 1'b1;
    wb.adr   = '0;
    wb.dat_i = '0;
    wb.we    = 1'b0;
    wb.cyc   = 1'b0;
    wb.stb   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_irq",  {31'd0, interrupt}, 32'd0);
    chk("rst_ack",  {31'd0, wb.ack}, 32'd0);
    chk("rst_dato", wb.dat_o, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rd_expect("rst_status", 2'd1, 32'h0000_0000);
    rd_expect("rst_ctrl",   2'd2, 32'h0000_0000);
    rd_expect("rst_data",   2'd0, 32'h0000_0000);
    rd_expect("reg3",       2'd3, 32'h0000_0000);

    // Basic frame
    ps2_frame(8'h1C, 1'b0, 1'b1, 11);
    rd_expect("f1c_status", 2'd1, 32'h0000_0101);
    rd_expect("f1c_data",   2'd0, 32'h8000_001C);
    rd_expect("f1c_data2",  2'd0, 32'h0000_0000);
    rd_expect("f1c_status2", 2'd1, 32'h0000_0000);

    // Interrupt
    wr(2'd2, 32'd1);
    rd_expect("ctrl_en", 2'd2, 32'h0000_0001);
    ps2_frame(8'hF0, 1'b0, 1'b1, 10);
    chk("irq_before_stop", {31'd0, interrupt}, 32'd0);
    ps2_bit(1'b1);
    chk("irq_after_stop", {31'd0, interrupt}, 32'd1);
    rd_expect("f0_data", 2'd0, 32'h8000_00F0);
    repeat (2) @(negedge clk);
    chk("irq_after_pop", {31'd0, interrupt}, 32'd0);
    wr(2'd2, 32'd0);

    // Parity error, then write-1-clear
    ps2_frame(8'h1C, 1'b1, 1'b1, 11);
    rd_expect("perr_status", 2'd1, 32'h0000_0004);
    wr(2'd1, 32'h0000_0004);
    rd_expect("perr_clear", 2'd1, 32'h0000_0000);

    // Fill past full
    for (int i = 1; i <= 17; i++) ps2_frame(8'(i), 1'b0, 1'b1, 11);
    rd_expect("full_status", 2'd1, 32'h0000_1013);
    for (int i = 1; i <= 16; i++) rd_expect("full_drain", 2'd0, 32'h8000_0000 | 32'(i));
    rd_expect("full_empty", 2'd0, 32'h0000_0000);
    wr(2'd1, 32'h0000_0010);
    rd_expect("ovf_clear", 2'd1, 32'h0000_0000);

    // Timeout on a partial frame
    ps2_frame(8'h00, 1'b0, 1'b1, 4);
    repeat (400) @(negedge clk);
    rd_expect("to_status", 2'd1, 32'h0000_0008);
    wr(2'd1, 32'h0000_0008);
    ps2_frame(8'h5A, 1'b0, 1'b1, 11);
    rd_expect("to_data", 2'd0, 32'h8000_005A);

    // Short clock glitch with data low must not start a frame
    @(negedge clk);
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (3) @(negedge clk);
    ps2_dat = 1'b1;
    repeat (400) @(negedge clk);
    rd_expect("glitch_status", 2'd1, 32'h0000_0000);

    // Reset in the middle of a frame with state present
    wr(2'd2, 32'd1);
    ps2_frame(8'h1C, 1'b1, 1'b1, 11);
    ps2_frame(8'h44, 1'b0, 1'b1, 11);
    chk("pre_rst_irq", {31'd0, interrupt}, 32'd1);
    ps2_frame(8'h33, 1'b0, 1'b1, 5);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_irq", {31'd0, interrupt}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rd_expect("midrst_status", 2'd1, 32'h0000_0000);
    rd_expect("midrst_ctrl",   2'd2, 32'h0000_0000);
    rd_expect("midrst_data",   2'd0, 32'h0000_0000);
    ps2_frame(8'h29, 1'b0, 1'b1, 11);
    rd_expect("post_rst_data", 2'd0, 32'h8000_0029);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
